fetch_prefetch_queue: RTL and testbench
=======================================

Name: fetch_prefetch_queue

Overview:
Fetch stage with a small prefetch FIFO. Sits between instruction memory and the instruction mux that feeds iDecode.
Keeps the PC, issues one-cycle-latency instruction reads, buffers returned words, and hands them to decode under a valid/ready handshake.
Handles execute-stage redirects (exeOverride/exeData) by flushing buffered and in-flight fetches. Replaces the free-running single-cycle fetch so decode can stall while the multiply microcode sequencer owns the mux.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of two, >= 2)
RESET_PC, 32'h0000_0000, PC value after reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request this cycle
imem_addr  output  32  fetch byte address (equals programCounter)
imem_rdata  input  32  instruction word, valid exactly 1 cycle after imem_req
exeOverride  input  1  branch taken / redirect pulse from execute
exeData  input  16  redirect target byte address, zero-extended to 32
halt  input  1  stop issuing new fetches (sticky until reset)
dec_ready  input  1  decode/mux accepts instruction (low while ucode owns mux)
inst_valid  output  1  inst_out holds a valid instruction
inst_out  output  32  head-of-queue instruction; 32'h0 when empty
inst_pc  output  32  PC of head-of-queue instruction; 32'h0 when empty
queue_count  output  $clog2(DEPTH)+1  entries currently buffered

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, FIFO empty, in-flight flag clear, epoch=0, halted=0. Outputs imem_req=0, inst_valid=0, inst_out=0, inst_pc=0, queue_count=0.
- Issue rule: imem_req = !halted && !exeOverride && (count + inflight < DEPTH).
- Issue effects: imem_addr=pc; the in-flight record {pc, epoch} is latched; pc <= pc + PC_STEP (32-bit wrap-around, no trap).
- Return: one cycle after a request, imem_rdata is written to the FIFO tail with its pc, but only if the in-flight epoch equals the current epoch; otherwise it is discarded.
- Pop: on inst_valid && dec_ready the head is removed. Push and pop in the same cycle leave count unchanged.
- Output: inst_out/inst_pc are driven combinationally from the head (zero when empty). Fall-through latency from request to inst_valid is 2 cycles: request at cycle N, rdata at N+1, registered into FIFO, visible at N+2.
- Redirect (exeOverride=1):
  - next cycle the FIFO is empty and epoch toggles;
  - pc <= {16'h0, exeData};
  - no request is issued in the redirect cycle;
  - a response arriving in or after the redirect cycle for an old-epoch request is dropped.
  - Redirect wins over a simultaneous pop (the pop is ignored) and over a simultaneous push.
- Halt: a rising halt sets halted. Outstanding responses still land; the queue drains normally; a later redirect updates pc but no fetch follows.
- Full: count==DEPTH means no request. The in-flight reservation guarantees a response never finds the FIFO full (no overflow path needed). An assertion flags a push while full.
- Empty with dec_ready=1: no pop, and count does not underflow.
- Pointer wrap-around: head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is held separately.

Decomposition:
- Shared package: fetch-queue entry struct {pc[31:0], inst[31:0]}, NOP_INST=32'h0, PC_STEP default.
- One sub-module: fetch_fifo. It is a synchronous DEPTH-entry FIFO with push, pop and flush, flush having priority, and exposes count/empty/full. Epoch handling and PC logic stay in the top.

Test Plan:
- Reset release, dec_ready=1, imem returns addr-as-data -> imem_addr 0,4,8,… on consecutive cycles; first inst_valid at cycle 2 with inst_out=0, inst_pc=0; sustained one instruction per cycle.
- dec_ready=0 from reset -> exactly 4 requests (0,4,8,12), queue_count=4, imem_req stays 0. Raise dec_ready -> pops 0,4,8,12 in order, and fetch resumes at 16.
- exeOverride=1 with exeData=16'h0100 while queue holds 3 entries and 1 in flight -> next cycle queue_count=0 and the in-flight word is dropped; next request is 32'h100 and next inst_pc=32'h100.
- Redirect in the same cycle as pop and push -> queue empty afterwards; no stale instruction ever appears on inst_out.
- halt=1 at pc=20 with 2 entries queued -> no further imem_req; entries 12 and 16 (plus in-flight 20) delivered, then inst_valid=0 and inst_out=0 permanently.
- Assert rst low mid-stream with queue full -> all outputs zero immediately (asynchronous). After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_queue_pkg.sv
// fetch_prefetch_queue_pkg: shared types and constants for the fetch stage and its prefetch FIFO
package fetch_prefetch_queue_pkg;

    // One buffered instruction together with the byte address it was fetched from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    // Value presented on the instruction outputs whenever nothing is buffered
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // Default byte increment between sequential fetches
    localparam int PC_STEP_DEF = 4;

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch entries with push, pop and priority flush
module fetch_fifo
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fq_entry_t                i_data,
    output fq_entry_t                o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t        r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Flush overrides both push and pop; popping an empty FIFO is ignored so count never underflows
    assign w_push  = i_push && !i_flush;
    assign w_pop   = i_pop && !i_flush && (r_count != '0);
    assign o_head  = r_mem[r_head];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));

    // Pointers wrap naturally modulo DEPTH; occupancy is tracked separately in r_count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Storage array carries no reset; the empty flag qualifies every read of the head
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= i_data;
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: PC keeper issuing one-cycle-latency fetches into a prefetch FIFO drained by decode
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = PC_STEP_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     exeOverride,
    input  logic [15:0]              exeData,
    input  logic                     halt,
    input  logic                     dec_ready,
    output logic                     inst_valid,
    output logic [31:0]              inst_out,
    output logic [31:0]              inst_pc,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]    r_pc;
    logic           r_epoch;
    logic           r_halted;
    logic           r_inflight;
    logic [31:0]    r_if_pc;
    logic           r_if_epoch;

    fq_entry_t      w_head;
    fq_entry_t      w_push_data;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_occupancy;
    logic           w_empty;
    logic           w_full;
    logic           w_req;
    logic           w_push;
    logic           w_pop;

    // An outstanding fetch reserves a slot, so the response can never find the FIFO full
    assign w_occupancy = w_count + CW'(r_inflight);
    assign w_req       = !r_halted && !exeOverride && (w_occupancy < CW'(DEPTH));
    // Responses from before the latest redirect carry a stale epoch and are dropped
    assign w_push      = r_inflight && (r_if_epoch == r_epoch) && !exeOverride;
    assign w_pop       = inst_valid && dec_ready;
    assign w_push_data = '{pc: r_if_pc, inst: imem_rdata};

    assign imem_req    = rst && w_req;
    assign imem_addr   = r_pc;
    assign inst_valid  = !w_empty;
    assign inst_out    = w_empty ? NOP_INST : w_head.inst;
    assign inst_pc     = w_empty ? 32'h0 : w_head.pc;
    assign queue_count = w_count;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (exeOverride),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // PC advance, redirect/epoch bookkeeping, in-flight record and sticky halt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_epoch    <= 1'b0;
            r_halted   <= 1'b0;
            r_inflight <= 1'b0;
            r_if_pc    <= 32'h0;
            r_if_epoch <= 1'b0;
        end else begin
            r_halted   <= r_halted | halt;
            r_inflight <= w_req;
            if (w_req) begin
                r_if_pc    <= r_pc;
                r_if_epoch <= r_epoch;
            end
            if (exeOverride) begin
                r_pc    <= {16'h0, exeData};
                r_epoch <= ~r_epoch;
            end else if (w_req) begin
                r_pc <= r_pc + 32'(PC_STEP);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(w_push && w_full));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: random and directed stimulus checked against a queue-based fetch model
module tb_fetch_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        exeOverride = 1'b0;
    logic [15:0] exeData = 16'h0;
    logic        halt = 1'b0;
    logic        dec_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [2:0]  queue_count;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .exeOverride (exeOverride),
        .exeData     (exeData),
        .halt        (halt),
        .dec_ready   (dec_ready),
        .inst_valid  (inst_valid),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .queue_count (queue_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_ifpc;
    logic [31:0] key;
    bit          m_inflight;
    bit          m_halted;
    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_inst;
    logic [31:0] s_pc;
    logic [31:0] s_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic do_reset(input logic [31:0] k);
        #3;
        rst = 1'b0;
        exeOverride = 1'b0;
        halt = 1'b0;
        dec_ready = 1'b0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst_out, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_cnt", queue_count, 0);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_pc = 32'h0;
        m_inflight = 0;
        m_halted = 0;
        key = k;
    endtask

    task automatic step(input bit o, input logic [15:0] d, input bit h, input bit r);
        bit          e_req;
        bit          e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        exeOverride = o;
        exeData = d;
        halt = h;
        dec_ready = r;
        imem_rdata = m_inflight ? memf(m_ifpc) : $urandom;
        #1;
        e_req   = !m_halted && !o && (q.size() + int'(m_inflight) < DEPTH);
        e_valid = q.size() > 0;
        e_inst  = e_valid ? q[0].inst : 32'h0;
        e_pc    = e_valid ? q[0].pc : 32'h0;
        chk("imem_req", imem_req, e_req);
        chk("imem_addr", imem_addr, m_pc);
        chk("inst_valid", inst_valid, e_valid);
        chk("inst_out", inst_out, e_inst);
        chk("inst_pc", inst_pc, e_pc);
        chk("queue_count", queue_count, q.size());
        s_req = imem_req;
        s_valid = inst_valid;
        s_addr = imem_addr;
        s_inst = inst_out;
        s_pc = inst_pc;
        s_cnt = 32'(queue_count);
        if (o) begin
            q.delete();
            m_pc = {16'h0, d};
            m_inflight = 0;
        end else begin
            if (e_valid && r) void'(q.pop_front());
            if (m_inflight) q.push_back('{m_ifpc, imem_rdata});
            m_inflight = e_req;
            if (e_req) begin
                m_ifpc = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end
        m_halted = m_halted | h;
        @(negedge clk);
    endtask

    initial begin
        int  nreq;
        bit  done;
        do_reset(32'h0);

        for (int i = 0; i < 8; i++) begin
            step(0, 16'h0, 0, 1);
            if (i == 0) begin chk("A_addr0", s_addr, 32'h0); chk("A_req0", s_req, 1); end
            if (i == 1) chk("A_addr1", s_addr, 32'h4);
            if (i == 2) begin chk("A_valid2", s_valid, 1); chk("A_inst2", s_inst, 32'h0); chk("A_pc2", s_pc, 32'h0); end
            if (i == 3) begin chk("A_pc3", s_pc, 32'h4); chk("A_inst3", s_inst, 32'h4); end
            if (i == 7) begin chk("A_valid7", s_valid, 1); chk("A_pc7", s_pc, 32'h14); end
        end

        do_reset(32'h0);
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 16'h0, 0, 0);
            nreq += int'(s_req);
        end
        chk("B_nreq", nreq, 4);
        chk("B_cnt", s_cnt, 4);
        chk("B_req", s_req, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 16'h0, 0, 1);
            if (i < 4) chk("B_pop_pc", s_pc, 32'(i * 4));
            if (i == 1) begin chk("B_resume", s_addr, 32'h10); chk("B_resume_req", s_req, 1); end
        end

        do_reset(32'h0);
        for (int i = 0; i < 4; i++) step(0, 16'h0, 0, 0);
        step(1, 16'h0100, 0, 0);
        chk("C_cnt_before", s_cnt, 3);
        step(0, 16'h0, 0, 1);
        chk("C_cnt_after", s_cnt, 0);
        chk("C_addr", s_addr, 32'h100);
        chk("C_req", s_req, 1);
        step(0, 16'h0, 0, 1);
        chk("C_valid_gap", s_valid, 0);
        step(0, 16'h0, 0, 1);
        chk("C_pc", s_pc, 32'h100);

        do_reset(32'h0);
        for (int i = 0; i < 4; i++) step(0, 16'h0, 0, 1);
        step(1, 16'h0200, 0, 1);
        step(0, 16'h0, 0, 1);
        chk("D_cnt", s_cnt, 0);
        chk("D_valid", s_valid, 0);
        chk("D_addr", s_addr, 32'h200);
        step(0, 16'h0, 0, 1);
        chk("D_inst_gap", s_inst, 32'h0);
        step(0, 16'h0, 0, 1);
        chk("D_pc", s_pc, 32'h200);

        do_reset(32'h0);
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            done = (m_pc == 32'd20);
            step(0, 16'h0, done, i % 3 != 0);
        end
        chk("E_halt_reached", done, 1);
        for (int i = 0; i < 10; i++) step(0, 16'h0, 0, 1);
        chk("E_req", s_req, 0);
        chk("E_valid", s_valid, 0);
        chk("E_inst", s_inst, 0);
        step(1, 16'h0040, 0, 1);
        step(0, 16'h0, 0, 1);
        chk("E_redir_addr", s_addr, 32'h40);
        chk("E_redir_req", s_req, 0);

        do_reset(32'h0);
        for (int i = 0; i < 6; i++) step(0, 16'h0, 0, 0);
        chk("F_full", s_cnt, 4);
        do_reset(32'h0);
        step(0, 16'h0, 0, 1);
        chk("F_addr", s_addr, 32'h0);
        chk("F_req", s_req, 1);

        for (int rnd = 0; rnd < 4; rnd++) begin
            do_reset($urandom);
            for (int i = 0; i < 700; i++)
                step($urandom_range(0, 15) == 0, 16'($urandom), (i > 600) && ($urandom_range(0, 99) == 0), $urandom_range(0, 9) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
